data_loop_controller: RTL and testbench

Per-pass tile sequencer on the data side of the WinoCNN main-controller handshake. While the main controller holds `data_prepare` high for one (input-depth, output-depth-pair) pass, this block walks every Winograd tile of the feature map in row-major order and issues it to the PE array over a valid/ready channel. It tracks outstanding tiles until the array reports completion, then returns a single-cycle `loop_finished` pulse, which advances the main controller's od/id counters.

---
 rtl/wino_pkg.sv | 23 ++
 rtl/tile_coord_counter.sv | 58 +++++
 rtl/data_loop_controller.sv | 142 ++++++++++++++
 tb/tb_data_loop_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_pkg.sv
// Shared types and constants for the WinoCNN data-side loop controller.
package wino_pkg;

    localparam int unsigned ID_W  = 4;
    localparam int unsigned BLK_W = 8;
    localparam int unsigned PIX_W = 9;

    localparam logic [PIX_W-1:0] TILE_STRIDE_F23 = 9'd4;
    localparam logic [PIX_W-1:0] TILE_STRIDE_F43 = 9'd6;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone,
        StWaitLow
    } data_loop_state_t;

    function automatic logic [PIX_W-1:0] tile_stride(input logic size_type);
        return size_type ? TILE_STRIDE_F23 : TILE_STRIDE_F43;
    endfunction

endpackage

// File: rtl/tile_coord_counter.sv
// Row-major tile walker: row/col counters and pixel-base accumulators for one pass.
module tile_coord_counter
    import wino_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [BLK_W-1:0] i_width,
    input  logic [BLK_W-1:0] i_height,
    input  logic [PIX_W-1:0] i_stride,
    output logic [BLK_W-1:0] o_row,
    output logic [BLK_W-1:0] o_col,
    output logic [PIX_W-1:0] o_base_x,
    output logic [PIX_W-1:0] o_base_y,
    output logic             o_last
);

    logic [BLK_W-1:0] r_row;
    logic [BLK_W-1:0] r_col;
    logic [PIX_W-1:0] r_base_x;
    logic [PIX_W-1:0] r_base_y;
    logic             w_last_col;

    assign w_last_col = (r_col == i_width - 8'd1);
    assign o_last     = w_last_col && (r_row == i_height - 8'd1);

    // Base accumulators wrap modulo 512 by construction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row    <= '0;
            r_col    <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
        end else if (i_clear) begin
            r_row    <= '0;
            r_col    <= '0;
            r_base_x <= '0;
            r_base_y <= '0;
        end else if (i_advance) begin
            if (w_last_col) begin
                r_col    <= '0;
                r_base_x <= '0;
                r_row    <= r_row + 8'd1;
                r_base_y <= r_base_y + i_stride;
            end else begin
                r_col    <= r_col + 8'd1;
                r_base_x <= r_base_x + i_stride;
            end
        end
    end

    assign o_row    = r_row;
    assign o_col    = r_col;
    assign o_base_x = r_base_x;
    assign o_base_y = r_base_y;

endmodule

// File: rtl/data_loop_controller.sv
// Per-pass Winograd tile sequencer with outstanding-tile tracking.
// Optional DATA_LOOP_PERF_EN adds a saturating ISSUE stall-cycle counter.
module data_loop_controller
    import wino_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             data_prepare_i,
    input  logic [BLK_W-1:0] block_width_i,
    input  logic [BLK_W-1:0] block_height_i,
    input  logic [ID_W-1:0]  data_id_i,
    input  logic             size_type_i,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [BLK_W-1:0] tile_row_o,
    output logic [BLK_W-1:0] tile_col_o,
    output logic [PIX_W-1:0] tile_base_x_o,
    output logic [PIX_W-1:0] tile_base_y_o,
    output logic [ID_W-1:0]  tile_id_o,
    output logic             tile_size_type_o,
    input  logic             tile_done_i,
    output logic             loop_finished_o,
    output logic             protocol_err_o
`ifdef DATA_LOOP_PERF_EN
    ,
    output logic [15:0]      perf_stall_cycles_o
`endif
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    data_loop_state_t r_state;
    logic [BLK_W-1:0] r_width;
    logic [BLK_W-1:0] r_height;
    logic [ID_W-1:0]  r_id;
    logic             r_size_type;
    logic             r_finished;
    logic [3:0]       r_outstanding;
    logic             r_err;

    logic             w_valid;
    logic             w_hs;
    logic             w_clear;
    logic             w_last;

    assign w_valid = (r_state == StIssue) && (r_outstanding < MaxOut);
    assign w_hs    = w_valid && tile_ready_i;
    assign w_clear = (r_state == StIdle) && data_prepare_i;

    tile_coord_counter u_coord (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_clear),
        .i_advance (w_hs),
        .i_width   (r_width),
        .i_height  (r_height),
        .i_stride  (tile_stride(r_size_type)),
        .o_row     (tile_row_o),
        .o_col     (tile_col_o),
        .o_base_x  (tile_base_x_o),
        .o_base_y  (tile_base_y_o),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_width     <= '0;
            r_height    <= '0;
            r_id        <= '0;
            r_size_type <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (data_prepare_i) begin
                        // Zero-sized blocks still produce a single tile.
                        r_width     <= (block_width_i == '0) ? 8'd1 : block_width_i;
                        r_height    <= (block_height_i == '0) ? 8'd1 : block_height_i;
                        r_id        <= data_id_i;
                        r_size_type <= size_type_i;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_hs && w_last) r_state <= StDrain;
                end
                StDrain: begin
                    if (r_outstanding == '0) begin
                        r_state    <= StDone;
                        r_finished <= 1'b1;
                    end
                end
                StDone:    r_state <= StWaitLow;
                StWaitLow: if (!data_prepare_i) r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            unique case ({w_hs, tile_done_i})
                2'b10: r_outstanding <= r_outstanding + 4'd1;
                2'b01: begin
                    if (r_outstanding == '0) r_err <= 1'b1;
                    else                     r_outstanding <= r_outstanding - 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DATA_LOOP_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_clear) begin
            r_stall <= '0;
        end else if ((r_state == StIssue) && !w_hs && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign perf_stall_cycles_o = r_stall;
`endif

    assign tile_valid_o     = w_valid;
    assign tile_id_o        = r_id;
    assign tile_size_type_o = r_size_type;
    assign loop_finished_o  = r_finished;
    assign protocol_err_o   = r_err;

endmodule

// File: tb/tb_data_loop_controller.sv
// Scoreboard bench for data_loop_controller: randomized passes against a tile-list model.
module tb_data_loop_controller;

    localparam int TB_MAX = 4;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [8:0] bx;
        logic [8:0] by;
        logic [3:0] id;
        logic       st;
    } desc_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       data_prepare_i = 1'b0;
    logic [7:0] block_width_i = '0;
    logic [7:0] block_height_i = '0;
    logic [3:0] data_id_i = '0;
    logic       size_type_i = 1'b0;
    logic       tile_ready_i = 1'b0;
    logic       tile_done_i = 1'b0;
    logic       tile_valid_o;
    logic [7:0] tile_row_o;
    logic [7:0] tile_col_o;
    logic [8:0] tile_base_x_o;
    logic [8:0] tile_base_y_o;
    logic [3:0] tile_id_o;
    logic       tile_size_type_o;
    logic       loop_finished_o;
    logic       protocol_err_o;
`ifdef DATA_LOOP_PERF_EN
    logic [15:0] perf_stall_cycles_o;
`endif

    always #5 clk = ~clk;

    data_loop_controller #(
        .MAX_OUTSTANDING (TB_MAX)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_prepare_i   (data_prepare_i),
        .block_width_i    (block_width_i),
        .block_height_i   (block_height_i),
        .data_id_i        (data_id_i),
        .size_type_i      (size_type_i),
        .tile_valid_o     (tile_valid_o),
        .tile_ready_i     (tile_ready_i),
        .tile_row_o       (tile_row_o),
        .tile_col_o       (tile_col_o),
        .tile_base_x_o    (tile_base_x_o),
        .tile_base_y_o    (tile_base_y_o),
        .tile_id_o        (tile_id_o),
        .tile_size_type_o (tile_size_type_o),
        .tile_done_i      (tile_done_i),
        .loop_finished_o  (loop_finished_o),
        .protocol_err_o   (protocol_err_o)
`ifdef DATA_LOOP_PERF_EN
        ,
        .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
    );

    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    desc_t exp_q[$];
    int    due_q[$];
    int    last_due = 0;
    int    last_done_cyc = -100;
    int    model_out = 0;
    bit    model_err = 1'b0;
    bit    in_issue = 1'b0;
    int    pass_cnt = 0;
    int    fin_cnt = 0;
    int    hs_cnt = 0;
    int    ready_pct = 100;
    int    dmin = 3;
    int    dmax = 3;
    bit    done_en = 1'b1;
    bit    spur_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ready and completion drivers: completions retire in issue order after a random delay.
    always @(posedge clk) begin
        #1;
        tile_ready_i = ($urandom_range(99) < ready_pct);
        if (!reset_n) begin
            tile_done_i = 1'b0;
        end else if (spur_req) begin
            tile_done_i = 1'b1;
            spur_req = 1'b0;
        end else if (done_en && due_q.size() > 0 && due_q[0] <= cyc) begin
            tile_done_i = 1'b1;
            void'(due_q.pop_front());
        end else begin
            tile_done_i = 1'b0;
        end
    end

    desc_t prev_desc;
    bit    prev_stall = 1'b0;

    always @(negedge clk) begin
        desc_t act;
        desc_t exp_d;
        bit    hs;
        int    due;
        act = {tile_row_o, tile_col_o, tile_base_x_o, tile_base_y_o, tile_id_o, tile_size_type_o};
        if (reset_n) begin
            hs = tile_valid_o && tile_ready_i;
            check("valid", tile_valid_o, in_issue && (model_out < TB_MAX));
            check("perr", protocol_err_o, model_err);
            if (prev_stall) check("stable", act, prev_desc);
            if (hs) begin
                hs_cnt++;
                check("tile_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    check("tile", act, exp_d);
                    if (exp_q.size() == 0) in_issue = 1'b0;
                end
                due = cyc + $urandom_range(dmax, dmin);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
            end
            if (tile_done_i) last_done_cyc = cyc;
            if (loop_finished_o) begin
                fin_cnt++;
                check("fin_latency", cyc - last_done_cyc, 2);
                check("fin_drained", exp_q.size() + model_out, 0);
            end
            if (hs && !tile_done_i) begin
                model_out++;
            end else if (!hs && tile_done_i) begin
                if (model_out == 0) model_err = 1'b1;
                else                model_out--;
            end
            prev_stall = tile_valid_o && !tile_ready_i;
            prev_desc  = act;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_pass(input int w, input int h, input int id, input bit st);
        int    we;
        int    he;
        int    stride;
        desc_t d;
        we = (w == 0) ? 1 : w;
        he = (h == 0) ? 1 : h;
        stride = st ? 4 : 6;
        for (int r = 0; r < he; r++) begin
            for (int c = 0; c < we; c++) begin
                d.row = 8'(r);
                d.col = 8'(c);
                d.bx  = 9'((c * stride) % 512);
                d.by  = 9'((r * stride) % 512);
                d.id  = 4'(id);
                d.st  = st;
                exp_q.push_back(d);
            end
        end
        block_width_i  = 8'(w);
        block_height_i = 8'(h);
        data_id_i      = 4'(id);
        size_type_i    = st;
        data_prepare_i = 1'b1;
        @(posedge clk);
        in_issue = 1'b1;
        @(negedge clk);
        check("first_valid", tile_valid_o, 1);
    endtask

    task automatic finish_pass();
        int guard;
        guard = 0;
        while (fin_cnt == pass_cnt && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        check("fin_seen", fin_cnt, pass_cnt + 1);
        pass_cnt++;
        repeat ($urandom_range(3, 0)) @(posedge clk);
        #1 data_prepare_i = 1'b0;
        @(posedge clk);
        #1;
        check("one_fin", fin_cnt, pass_cnt);
    endtask

    initial begin
        int h0;
        #1;
        check("rst_desc", {tile_row_o, tile_col_o, tile_base_x_o, tile_base_y_o,
                           tile_id_o, tile_size_type_o}, 0);
        check("rst_valid", tile_valid_o, 0);
        check("rst_fin", loop_finished_o, 0);
        check("rst_err", protocol_err_o, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        ready_pct = 100; dmin = 3; dmax = 3;
        start_pass(2, 2, 5, 1'b1);
        finish_pass();
        start_pass(3, 1, 3, 1'b0);
        finish_pass();

        // Outstanding limit: no completions until the window fills.
        dmin = 1; dmax = 1; done_en = 1'b0;
        h0 = hs_cnt;
        start_pass(3, 3, 11, 1'b1);
        repeat (8) @(posedge clk);
        check("max_hs", hs_cnt - h0, TB_MAX);
        done_en = 1'b1;
        @(posedge clk);
        done_en = 1'b0;
        repeat (5) @(posedge clk);
        check("one_more_hs", hs_cnt - h0, TB_MAX + 1);
        done_en = 1'b1;
        finish_pass();

        start_pass(0, 0, 7, 1'b1);
        finish_pass();

        for (int i = 0; i < 8; i++) begin
            ready_pct = $urandom_range(100, 40);
            dmin = 1;
            dmax = $urandom_range(8, 1);
            start_pass($urandom_range(6, 0), $urandom_range(5, 0), $urandom_range(15),
                       1'($urandom_range(1)));
            finish_pass();
        end

        ready_pct = 100; dmin = 1; dmax = 3;
        start_pass(90, 2, 9, 1'b0);
        finish_pass();

        // Reset mid-ISSUE, then release with prepare still high.
        dmin = 2; dmax = 4;
        start_pass(5, 4, 6, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_desc", {tile_row_o, tile_col_o, tile_base_x_o, tile_base_y_o,
                               tile_id_o, tile_size_type_o}, 0);
        check("mid_rst_valid", tile_valid_o, 0);
        check("mid_rst_fin", loop_finished_o, 0);
        exp_q.delete();
        due_q.delete();
        model_out = 0;
        model_err = 1'b0;
        in_issue = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        start_pass(3, 2, 12, 1'b0);
        finish_pass();

        // Completion with nothing outstanding is flagged and sticks.
        spur_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("err_set", protocol_err_o, 1);
        ready_pct = 70; dmin = 1; dmax = 5;
        start_pass(4, 3, 2, 1'b1);
        finish_pass();
        check("err_sticky", protocol_err_o, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
